// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - producer/consumer handshake bundle for sync_fifo_flags
//
// Purpose: groups the write, read and status signals of one FIFO instance.
// Ports (by modport):
//   master : drives wr_en, din, rd_en; observes dout, full, empty,
//            almost_full, almost_empty, count, overflow, underflow
//   slave  : the FIFO side, opposite directions
interface sync_fifo_flags_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with exact count, programmable flags and FWFT option
//
// Purpose: general-purpose same-domain buffer. Flags are registered from the
// next-state count so they always agree with count.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears pointers, count, flags, dout
//   bus   : sync_fifo_flags_if.slave (wr_en/din/rd_en in; dout, full, empty,
//           almost_full, almost_empty, count, overflow, underflow out)
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_flags_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic             full_q;
  logic             empty_q;
  logic             af_q;
  logic             ae_q;
  logic             ov_q;
  logic             uf_q;
  logic [WIDTH-1:0] dout_q;
  logic             wr_acc;
  logic             rd_acc;

  // Depth need not be a power of two, so wrap by compare rather than overflow.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // Acceptance uses the registered flags only: a same-cycle read never makes
  // room for a write at full, and a same-cycle write never feeds a read at empty.
  assign wr_acc = bus.wr_en && !full_q;
  assign rd_acc = bus.rd_en && !empty_q;

  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc) begin
      count_nxt = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count_q - 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= (AF_LEVEL == 0);
      ae_q    <= 1'b1;
      ov_q    <= 1'b0;
      uf_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH_C);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_C);
      ae_q    <= (count_nxt <= AE_C);
      ov_q    <= bus.wr_en && full_q;
      uf_q    <= bus.rd_en && empty_q;
      if (FWFT == 0 && rd_acc) begin
        dout_q <= mem[rd_ptr];
      end
    end
  end

  // FWFT shows the head word directly; it is forced to zero while empty so the
  // output matches the reset value instead of exposing unwritten storage.
  assign bus.dout         = (FWFT != 0) ? (empty_q ? '0 : mem[rd_ptr]) : dout_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ov_q;
  assign bus.underflow    = uf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - randomized and directed bench for sync_fifo_flags against a queue model
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // d0: default standard mode, d1: DEPTH=5 standard, d2: default FWFT
  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(16)) f0 ();
  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(5))  f1 ();
  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(16)) f2 ();

  assign f0.wr_en = wr_en;  assign f0.din = din;  assign f0.rd_en = rd_en;
  assign f1.wr_en = wr_en;  assign f1.din = din;  assign f1.rd_en = rd_en;
  assign f2.wr_en = wr_en;  assign f2.din = din;  assign f2.rd_en = rd_en;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) d0 (
    .clk(clk), .reset(reset), .bus(f0));
  sync_fifo_flags #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) d1 (
    .clk(clk), .reset(reset), .bus(f1));
  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) d2 (
    .clk(clk), .reset(reset), .bus(f2));

  // Reference model: one queue per instance plus the last-read word.
  int         m_depth [3] = '{16, 5, 16};
  int         m_af    [3] = '{14, 4, 14};
  int         m_ae    [3] = '{2, 1, 2};
  int         m_fwft  [3] = '{0, 0, 1};
  logic [7:0] mq      [3][$];
  logic [7:0] m_dout  [3];
  bit         m_ov    [3];
  bit         m_uf    [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      m_dout[k] = 8'h00;
      m_ov[k]   = 1'b0;
      m_uf[k]   = 1'b0;
    end
  endtask

  task automatic model_step(input logic w, input logic [7:0] d, input logic r);
    for (int k = 0; k < 3; k++) begin
      int  size;
      bit  wa;
      bit  ra;
      size    = mq[k].size();
      wa      = w && (size < m_depth[k]);
      ra      = r && (size > 0);
      m_ov[k] = w && (size == m_depth[k]);
      m_uf[k] = r && (size == 0);
      if (ra) begin
        if (m_fwft[k] == 0) m_dout[k] = mq[k].pop_front();
        else void'(mq[k].pop_front());
      end
      if (wa) mq[k].push_back(d);
    end
  endtask

  task automatic cmp_dut(input int k, input logic [31:0] cnt, input logic fu, input logic em,
                         input logic af, input logic ae, input logic ov, input logic uf,
                         input logic [7:0] dq);
    int size;
    size = mq[k].size();
    check($sformatf("d%0d count", k), cnt, size);
    check($sformatf("d%0d full", k), {31'b0, fu}, {31'b0, size == m_depth[k]});
    check($sformatf("d%0d empty", k), {31'b0, em}, {31'b0, size == 0});
    check($sformatf("d%0d almost_full", k), {31'b0, af}, {31'b0, size >= m_af[k]});
    check($sformatf("d%0d almost_empty", k), {31'b0, ae}, {31'b0, size <= m_ae[k]});
    check($sformatf("d%0d overflow", k), {31'b0, ov}, {31'b0, m_ov[k]});
    check($sformatf("d%0d underflow", k), {31'b0, uf}, {31'b0, m_uf[k]});
    if (m_fwft[k] == 0) check($sformatf("d%0d dout", k), {24'b0, dq}, {24'b0, m_dout[k]});
    else if (size > 0)  check($sformatf("d%0d dout_fwft", k), {24'b0, dq}, {24'b0, mq[k][0]});
  endtask

  task automatic compare_all();
    cmp_dut(0, 32'(f0.count), f0.full, f0.empty, f0.almost_full, f0.almost_empty,
            f0.overflow, f0.underflow, f0.dout);
    cmp_dut(1, 32'(f1.count), f1.full, f1.empty, f1.almost_full, f1.almost_empty,
            f1.overflow, f1.underflow, f1.dout);
    cmp_dut(2, 32'(f2.count), f2.full, f2.empty, f2.almost_full, f2.almost_empty,
            f2.overflow, f2.underflow, f2.dout);
  endtask

  // Called at a falling edge: drive, take the rising edge, check at the next falling edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    model_step(w, d, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    do_reset();

    // Fill: d0/d2 reach full at 16, d1 saturates at 5 and overflows.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      if (i == 13) check("d0 af_below_level", {31'b0, f0.almost_full}, 32'd0);
      if (i == 14) check("d0 af_at_level", {31'b0, f0.almost_full}, 32'd1);
    end
    check("d0 full_after_16", {31'b0, f0.full}, 32'd1);
    check("d0 count_after_16", 32'(f0.count), 32'd16);
    cycle(1'b1, 8'h77, 1'b0);
    check("d0 overflow_17th", {31'b0, f0.overflow}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0);
    check("d0 overflow_one_cycle", {31'b0, f0.overflow}, 32'd0);

    // Drain plus one extra read.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("d0 drain_dout", {24'b0, f0.dout}, 32'(i));
    end
    cycle(1'b0, 8'h00, 1'b1);
    check("d0 underflow_extra", {31'b0, f0.underflow}, 32'd1);
    check("d0 dout_holds", {24'b0, f0.dout}, 32'h10);

    // Wrap-around pattern (exercises d1 pointer wrap).
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    check("d1 wrap_count_zero", 32'(f1.count), 32'd0);

    // Simultaneous read/write at 8, at full, at empty.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b1);
    check("d0 simul_count8", 32'(f0.count), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    check("d0 simul_full_count", 32'(f0.count), 32'd15);
    check("d0 simul_full_ovf", {31'b0, f0.overflow}, 32'd1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h99, 1'b1);
    check("d0 simul_empty_count", 32'(f0.count), 32'd1);
    check("d0 simul_empty_udf", {31'b0, f0.underflow}, 32'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // FWFT head word visible without rd_en.
    cycle(1'b1, 8'hA5, 1'b0);
    check("d2 fwft_dout", {24'b0, f2.dout}, 32'hA5);
    check("d2 fwft_not_empty", {31'b0, f2.empty}, 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    check("d2 fwft_pop_empty", {31'b0, f2.empty}, 32'd1);
    check("d2 fwft_pop_count", 32'(f2.count), 32'd0);

    // Randomized phases with varying write/read bias.
    for (int p = 0; p < 4; p++) begin
      int wp;
      int rp;
      wp = (p == 0) ? 80 : (p == 1) ? 20 : 50;
      rp = (p == 0) ? 20 : (p == 1) ? 80 : (p == 2) ? 50 : 95;
      for (int i = 0; i < 500; i++) begin
        cycle($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp);
      end
    end

    // Asynchronous reset at count 9, between edges.
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0);
    check("d0 pre_areset_count", 32'(f0.count), 32'd9);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("d0 areset_count", 32'(f0.count), 32'd0);
    check("d0 areset_empty", {31'b0, f0.empty}, 32'd1);
    check("d0 areset_full", {31'b0, f0.full}, 32'd0);
    check("d0 areset_dout", {24'b0, f0.dout}, 32'd0);
    check("d1 areset_count", 32'(f1.count), 32'd0);
    check("d2 areset_empty", {31'b0, f2.empty}, 32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    compare_all();
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("d0 post_reset_data", {24'b0, f0.dout}, 32'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds, an exact occupancy count, a selectable standard or first-word-fall-through (FWFT) read mode, and single-cycle overflow/underflow error pulses. It serves as the general-purpose buffering element between producer and consumer blocks in the same clock domain. Status flags are exact in the cycle after each access; they do not lag by a cycle.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of storage words (≥2; need not be a power of two)
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- wr_en  input  1  write request
- din  input  WIDTH  write data, sampled when a write is accepted
- rd_en  input  1  read request (standard mode) / pop acknowledge (FWFT mode)
- dout  output  WIDTH  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  $clog2(DEPTH+1)  number of words currently stored
- overflow  output  1  one-cycle pulse: a write was rejected
- underflow  output  1  one-cycle pulse: a read was rejected

## Operation
- Write accepted iff wr_en && !full. On acceptance, din is stored at wr_ptr and wr_ptr advances.
- Read accepted iff rd_en && !empty. On acceptance, rd_ptr advances.
- Acceptance is evaluated against the flags at the start of the cycle. A read in the same cycle does not free space for a write when full. A write in the same cycle does not make data available for a read when empty.
- Pointers are in the range 0..DEPTH-1 and wrap from DEPTH-1 to 0 by explicit compare, not by binary overflow.
- count: +1 on write only, −1 on read only, unchanged when both or neither are accepted. It never exceeds DEPTH and never goes below 0.
- full, empty, almost_full and almost_empty are registered. Each is computed from the next value of count, so it is consistent with count in every cycle.
- Standard mode (FWFT=0): on an accepted read, dout ← mem[rd_ptr] at that edge. Otherwise dout holds its last value.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] combinationally whenever !empty, so the head word is visible before rd_en. dout is don't-care while empty. rd_en pops the head word.
- overflow ← wr_en && full; underflow ← rd_en && empty. Both are registered pulses lasting exactly one cycle per rejected request. Rejected requests change no other state.
- Storage array is not reset. Its contents are undefined until written.

## Timing
- Reset values: dout=0, count=0, full=0, empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), almost_empty=1, overflow=0, underflow=0. Pointers are 0.
- Reset asserted mid-operation discards all stored words immediately (asynchronous). The first access is accepted on the first rising edge after reset deasserts.
- Standard mode read latency: 1 cycle from an accepted rd_en to dout.
- FWFT mode: a word written into an empty FIFO appears on dout in the cycle after the write edge, when empty drops.
- Write-to-empty-deassert: 1 cycle. Read-to-full-deassert: 1 cycle.
- Sustained throughput: one write and one read per cycle when neither full nor empty.

## Test plan
- Reset, then write 0x01..0x10 (16 words, default parameters): full=1 and count=16 after the 16th edge; almost_full rises at count=14. A 17th write gives overflow=1 for one cycle with count still 16.
- From full, read 16 times in standard mode: dout=0x01..0x10 in order, each one cycle after its rd_en. empty=1 after the last read. An extra rd_en gives underflow=1 for one cycle and dout holds 0x10.
- Wrap-around with DEPTH=5: run 3 writes, 3 reads, then 4 writes and 4 reads. Data order is preserved across the pointer wrap, and count returns to 0.
- Simultaneous wr_en+rd_en at count=8: count stays 8 and data order is intact. At full, the read is accepted, the write is rejected, overflow pulses and count=15. At empty, the write is accepted, the read is rejected, underflow pulses and count=1.
- FWFT=1: write 0xA5 into an empty FIFO. dout=0xA5 with empty=0 in the next cycle, with no rd_en. Pulse rd_en once: empty=1 and count=0.
- Reset asserted asynchronously at count=9 between clock edges: count=0, empty=1, full=0 and dout=0 immediately. A subsequent write/read of 0x3C returns 0x3C.
